nco_bank_tdm: RTL

- Parametrised successor of the 4-voice NCO bank: VOICES oscillators time-multiplexed over one shared step-size ROM port and one shared waveform ROM port, driven by a sequencing FSM rather than a one-hot trigger shift chain.
- Adds per-voice gate with phase retrigger, velocity scaling, a saturating mixer, and overrun detection.
- Sits between the MIDI voice allocator (note/velocity/gate per voice) and the output sample register / DAC path.

---
 rtl/nco_bank_tdm.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/nco_bank_tdm.sv
// Time-multiplexed bank of VOICES phase-accumulator oscillators sharing one step ROM
// and one waveform ROM port, with per-voice gate/retrigger, velocity scaling and a saturating mixer.
module nco_bank_tdm #(
   parameter int VOICES    = 8,
   parameter int DIV       = 3125,
   parameter int MIX_SHIFT = 3
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  CE,
   input  logic [7*VOICES-1:0]   NOTE_NUM,
   input  logic [7*VOICES-1:0]   NOTE_VEL,
   input  logic [VOICES-1:0]     GATE,
   output logic                  STEP_RD,
   output logic [6:0]            STEP_ADDR,
   input  logic [15:0]           STEP_SIZE,
   output logic                  WAVE_RD,
   output logic [6:0]            WAVE_PHASE,
   input  logic [7:0]            WAVE_SAMPLE,
   output logic [7:0]            SAMPLE_OUT,
   output logic                  SAMPLE_VALID,
   output logic                  BUSY,
   output logic                  OVERRUN
);

   localparam int VW = $clog2(VOICES);
   localparam int MW = 8 + VW;
   localparam int CW = $clog2(DIV);

   typedef enum logic [2:0] {S_IDLE, S_ADDR, S_STEP, S_WAVE, S_OUT} state_t;

   state_t             state;
   logic [CW-1:0]      cnt;
   logic               tick;
   logic [VW-1:0]      vi;
   logic [MW-1:0]      mix;
   logic [15:0]        acc [VOICES];
   logic [VOICES-1:0]  gate_prev;
   logic [6:0]         phase_q;

   int                 vidx;
   int                 nidx;
   logic               gate_v;
   logic               rise;
   logic [6:0]         vel_v;
   logic [6:0]         note_next;
   logic [15:0]        acc_new;
   logic [7:0]         term;
   logic [MW-1:0]      mix_add;
   logic [MW-1:0]      mix_sh;
   logic [7:0]         sat;

   assign tick = (cnt == CW'(DIV - 1));

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cnt <= '0;
      end else if (CE) begin
         cnt <= tick ? '0 : cnt + 1'b1;
      end
   end

   // Datapath for the voice currently being visited; nidx is the next voice slot.
   always_comb begin
      vidx      = int'(vi);
      nidx      = (vi == VW'(VOICES - 1)) ? 0 : vidx + 1;
      gate_v    = GATE[vi];
      rise      = gate_v & ~gate_prev[vi];
      vel_v     = NOTE_VEL[7*vidx +: 7];
      note_next = NOTE_NUM[7*nidx +: 7];
      acc_new   = acc[vi];
      if (gate_v) acc_new = (rise ? 16'd0 : acc[vi]) + STEP_SIZE;
      term      = 8'((15'(WAVE_SAMPLE) * 15'(vel_v)) >> 7);
      mix_add   = gate_prev[vi] ? mix + MW'(term) : mix;
      mix_sh    = mix_add >> MIX_SHIFT;
      sat       = (mix_sh > MW'(255)) ? 8'hff : mix_sh[7:0];
   end

   // The waveform address follows the freshly updated accumulator during STEP, then holds.
   assign WAVE_PHASE = (state == S_STEP) ? acc_new[15:9] : phase_q;
   assign BUSY       = (state != S_IDLE);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state        <= S_IDLE;
         vi           <= '0;
         mix          <= '0;
         gate_prev    <= '0;
         phase_q      <= '0;
         STEP_RD      <= 1'b0;
         STEP_ADDR    <= '0;
         WAVE_RD      <= 1'b0;
         SAMPLE_OUT   <= '0;
         SAMPLE_VALID <= 1'b0;
         OVERRUN      <= 1'b0;
         for (int i = 0; i < VOICES; i++) acc[i] <= '0;
      end else if (CE) begin
         STEP_RD      <= 1'b0;
         WAVE_RD      <= 1'b0;
         SAMPLE_VALID <= 1'b0;
         if (tick && state != S_IDLE) OVERRUN <= 1'b1;
         case (state)
            S_IDLE: begin
               if (tick) begin
                  vi        <= '0;
                  mix       <= '0;
                  STEP_RD   <= 1'b1;
                  STEP_ADDR <= NOTE_NUM[6:0];
                  state     <= S_ADDR;
               end
            end
            S_ADDR: begin
               WAVE_RD <= 1'b1;
               state   <= S_STEP;
            end
            S_STEP: begin
               acc[vi]       <= acc_new;
               gate_prev[vi] <= gate_v;
               phase_q       <= acc_new[15:9];
               state         <= S_WAVE;
            end
            S_WAVE: begin
               mix <= mix_add;
               if (vi == VW'(VOICES - 1)) begin
                  SAMPLE_OUT   <= sat;
                  SAMPLE_VALID <= 1'b1;
                  state        <= S_OUT;
               end else begin
                  vi        <= vi + 1'b1;
                  STEP_RD   <= 1'b1;
                  STEP_ADDR <= note_next;
                  state     <= S_ADDR;
               end
            end
            S_OUT: begin
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
